// File: rtl/el2_ifu_pkg.sv
// Shared definitions for the IFU halfword alignment queue: default queue
// depth, halfword-count encoding and the compressed-instruction detector.
package el2_ifu_pkg;

  localparam int ALIGN_DEPTH_DEF = 8;

  // Number of halfwords moved into or out of the queue in one cycle.
  typedef enum logic [1:0] {
    HW_NONE = 2'd0,
    HW_ONE  = 2'd1,
    HW_TWO  = 2'd2
  } hw_cnt_e;

  // A halfword opens a 16-bit instruction unless its low two bits are 2'b11.
  function automatic logic el2_ifu_is_compressed(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/el2_ifu_hw_fifo.sv
// Halfword FIFO for the alignment queue. Accepts 0/1/2 halfwords and
// releases 0/1/2 halfwords per cycle; the two halfwords at the read pointer
// are always visible. Flush empties the queue and wins over push and pop.
module el2_ifu_hw_fifo
  import el2_ifu_pkg::*;
#(
  parameter int DEPTH = ALIGN_DEPTH_DEF,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             flush,
  input  logic [1:0]       push_n,
  input  logic [WIDTH-1:0] wr_hw0,
  input  logic [WIDTH-1:0] wr_hw1,
  input  logic [1:0]       pop_n,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] rd_hw0,
  output logic [WIDTH-1:0] rd_hw1
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr_p1;
  logic [AW-1:0]    rd_ptr_p1;

  // Pointers wrap naturally because DEPTH is a power of two.
  assign wr_ptr_p1 = wr_ptr + AW'(1);
  assign rd_ptr_p1 = rd_ptr + AW'(1);

  // Storage write: first halfword at wr_ptr, second (if any) right after it.
  // NOTE: the storage array has no reset; every entry is written before the
  // count makes it visible, so resetting it would only add reset fan-out.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) mem[wr_ptr] <= wr_hw0;
    if (push_n == 2'd2) mem[wr_ptr_p1] <= wr_hw1;
  end

  // Pointer and occupancy bookkeeping; flush clears everything.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_n);
      rd_ptr <= rd_ptr + AW'(pop_n);
      count  <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  assign rd_hw0 = mem[rd_ptr];
  assign rd_hw1 = mem[rd_ptr_p1];

endmodule

// File: rtl/el2_ifu_align_q.sv
// IFU halfword alignment queue. Buffers 32-bit fetch packets as halfwords
// and presents one 16- or 32-bit instruction per cycle to decode together
// with its PC. Optional per-halfword parity checking is enabled by defining
// ALIGN_PARITY_EN; without it fetch parity is ignored and aln_perr is 0.
module el2_ifu_align_q
  import el2_ifu_pkg::*;
#(
  parameter int DEPTH = ALIGN_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        exu_flush_final,
  input  logic [30:0] exu_flush_path,
  input  logic        ifu_fetch_valid,
  input  logic [31:0] ifu_fetch_data,
  input  logic [30:0] ifu_fetch_pc,
  input  logic [1:0]  ifu_fetch_par,
  output logic        ifu_fetch_ready,
  output logic        aln_valid,
  output logic [31:0] aln_instr,
  output logic [15:0] aln_cinst,
  output logic        aln_is_16,
  output logic [30:0] aln_pc,
  output logic        aln_perr,
  input  logic        dec_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef ALIGN_PARITY_EN
  localparam int WIDTH = 17;
`else
  localparam int WIDTH = 16;
`endif

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] wr_hw0;
  logic [WIDTH-1:0] wr_hw1;
  logic [WIDTH-1:0] rd_hw0;
  logic [WIDTH-1:0] rd_hw1;
  logic [15:0]      in_hw0;
  logic [15:0]      head_hw;
  logic [15:0]      next_hw;
  logic [30:0]      head_pc;
  logic             upper_only;
  logic             push_fire;
  logic             pop_fire;
  logic             has1;
  logic             has2;
  logic             is16;
  hw_cnt_e          push_n;
  hw_cnt_e          pop_n;

  // PC bit 1 set means the packet starts on its upper halfword; the rest of
  // the fetch PC is only meaningful to the producer's sequencing.
  assign upper_only = ifu_fetch_pc[0];
  logic unused_pc;
  assign unused_pc = ^ifu_fetch_pc[30:1];

  assign in_hw0 = upper_only ? ifu_fetch_data[31:16] : ifu_fetch_data[15:0];

`ifdef ALIGN_PARITY_EN
  logic in_par0;
  assign in_par0 = upper_only ? ifu_fetch_par[1] : ifu_fetch_par[0];
  assign wr_hw0  = {in_par0, in_hw0};
  assign wr_hw1  = {ifu_fetch_par[1], ifu_fetch_data[31:16]};
`else
  logic unused_par;
  assign unused_par = ^ifu_fetch_par;
  assign wr_hw0     = in_hw0;
  assign wr_hw1     = ifu_fetch_data[31:16];
`endif

  // Space check uses the registered count only, so a same-cycle pop never
  // creates a path from decode back into fetch.
  assign ifu_fetch_ready = (count <= CW'(DEPTH - 2));
  assign push_fire       = ifu_fetch_valid & ifu_fetch_ready & ~exu_flush_final;

  assign head_hw = rd_hw0[15:0];
  assign next_hw = rd_hw1[15:0];
  assign has1    = (count != '0);
  assign has2    = (count >= CW'(2));
  assign is16    = el2_ifu_is_compressed(head_hw);

  // A 32-bit instruction whose upper half has not arrived keeps valid low.
  assign aln_valid = ~exu_flush_final & ((has1 & is16) | has2);
  assign pop_fire  = aln_valid & dec_ready;

  // Halfword counts handed to the FIFO for this cycle's push and pop.
  // NOTE: every always_comb output gets a default first so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    push_n = HW_NONE;
    pop_n  = HW_NONE;
    if (push_fire) push_n = upper_only ? HW_ONE : HW_TWO;
    if (pop_fire)  pop_n  = is16 ? HW_ONE : HW_TWO;
  end

  el2_ifu_hw_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk    (clk),
    .rst_l  (rst_l),
    .flush  (exu_flush_final),
    .push_n (push_n),
    .wr_hw0 (wr_hw0),
    .wr_hw1 (wr_hw1),
    .pop_n  (pop_n),
    .count  (count),
    .rd_hw0 (rd_hw0),
    .rd_hw1 (rd_hw1)
  );

  // Head PC: redirect on flush, otherwise advance by the halfwords popped.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      head_pc <= '0;
    end else if (exu_flush_final) begin
      head_pc <= exu_flush_path;
    end else begin
      head_pc <= head_pc + 31'(pop_n);
    end
  end

  // Output formatting; empty-queue storage is masked so outputs stay clean.
  assign aln_pc    = head_pc;
  assign aln_cinst = has1 ? head_hw : 16'h0;
  assign aln_is_16 = has1 & is16;
  assign aln_instr = !aln_valid ? 32'h0 :
                     is16       ? {16'h0, head_hw} : {next_hw, head_hw};

`ifdef ALIGN_PARITY_EN
  logic perr0;
  logic perr1;
  assign perr0    = rd_hw0[16] ^ (^rd_hw0[15:0]);
  assign perr1    = rd_hw1[16] ^ (^rd_hw1[15:0]);
  assign aln_perr = aln_valid & (perr0 | (~is16 & perr1));
`else
  assign aln_perr = 1'b0;
`endif

endmodule
